rotator_arbiter: RTL and testbench
==================================

# rotator_arbiter

Shares one 8-bit `Barrel_Rotator` between two requesters on a single clock. Each request is a rotate command: data, direction and amount. The block arbitrates between pending requests and drives the winning command into the combinational rotator. It captures the rotated result in a one-entry output register behind a valid/ready handshake, and keeps saturating per-requester completion counters for the board-level status display.

## Interface

Parameters:
- `CNT_W`, default 16: width of each completion counter.

Ports:
- `clk`, in, 1: the only clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req0_valid`, in, 1: requester 0 has a command.
- `req0_ready`, out, 1: requester 0 command accepted this cycle.
- `req0_data`, in, 8: data to rotate.
- `req0_lr`, in, 1: direction; 1 = rotate left, 0 = rotate right.
- `req0_amount`, in, 3: rotate amount, 0–7.
- `req1_valid`, `req1_ready`, `req1_data`, `req1_lr`, `req1_amount`: same as requester 0, for requester 1.
- `rsp_valid`, out, 1: output register holds a result.
- `rsp_ready`, in, 1: consumer takes the result.
- `rsp_data`, out, 8: rotated result.
- `rsp_id`, out, 1: index of the requester that issued the result.
- `cnt0`, out, `CNT_W`: requester 0 completions, saturating.
- `cnt1`, out, `CNT_W`: requester 1 completions, saturating.

## Operation

- One `Barrel_Rotator` instance. Its `data_in`, `lr` and `amount` are muxed from the granted requester; `data_out` goes to the output register.
- FSM has two states: EMPTY (output register free) and FULL (result held).
- `slot_free` = EMPTY, or (FULL && `rsp_ready`).
- Grant:
  - Computed combinationally from `req0_valid`, `req1_valid` and the `last` pointer.
  - With both valid, the requester not equal to `last` wins.
  - With one valid, that requester wins.
- `reqN_ready` = grant to N && `slot_free`. At most one ready per cycle. Ready does not depend on that requester's own valid beyond arbitration.
- Accept = `reqN_valid && reqN_ready`. On accept, all of the following load at the next edge:
  - `rsp_data` ← rotated data; `rsp_id` ← N; `rsp_valid` ← 1
  - `last` ← N
  - `cntN` increments, saturating at all-ones.
- Drain = `rsp_valid && rsp_ready`.
  - Drain without accept: go to EMPTY, `rsp_valid` ← 0.
  - Drain and accept in the same cycle: stay FULL and load the new result. This gives throughput of one command per cycle.
- FULL with `rsp_ready` low: `rsp_data` and `rsp_id` hold stable; both readies are 0.
- `amount` = 0 passes the data unchanged. `lr` is ignored in that case.
- Requesters must hold valid and command fields stable until accepted. The block does not require this for correctness; an unaccepted request is simply re-arbitrated each cycle.

## Timing

- Reset values: `rsp_valid` = 0, `rsp_data` = 8'h00, `rsp_id` = 0, `cnt0` = `cnt1` = 0, `last` = 1 (so requester 0 wins the first tie), state EMPTY.
- Readies are combinational and fall to 0 while `rst` is high.
- Latency: a command accepted at edge k appears on `rsp_valid`/`rsp_data` after edge k.
- Reset mid-operation: a held result is discarded and counters clear. A command presented in the reset cycle is not accepted.
- There is no combinational path from `reqN_*` to `rsp_*`. `rsp_ready` reaches the readies combinationally.
- Counter saturation: a counter at all-ones stays at all-ones; the result is still delivered.

## Configuration

- `ROTATOR_ARB_RR_EN` defined: round-robin grant as described under Operation.
- Undefined: fixed priority; requester 0 always wins a tie and the `last` pointer is not implemented. All other behaviour is identical.

## Test plan

- **Reset:** hold `rst` for 2 cycles with both valids high.
  - Required: both readies 0, `rsp_valid` 0, counters 0.
- **Single left rotate:** req0 sends data 8'h81, `lr` = 1, amount 1, with `rsp_ready` = 1.
  - Required: accepted in 1 cycle; next cycle `rsp_data` = 8'h03, `rsp_id` = 0, `cnt0` = 1.
- **Right rotate and zero amount:** req1 sends 8'h81, `lr` = 0, amount 1, then 8'hA5 with amount 0.
  - Required: results 8'hC0 then 8'hA5, `rsp_id` = 1.
- **Contention under round-robin:** both requesters valid continuously for 4 cycles with `rsp_ready` = 1.
  - Required: grants 0, 1, 0, 1, one result per cycle, `cnt0` = `cnt1` = 2.
  - Without the macro: grants 0, 0, 0, 0.
- **Backpressure:** `rsp_ready` = 0 while FULL for 5 cycles.
  - Required: readies 0, `rsp_data` stable; the cycle `rsp_ready` rises, a new command is accepted and the next result loads on that edge.
- **Saturation:** with `CNT_W` = 2, issue 5 req0 commands.
  - Required: `cnt0` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/rotator_arbiter.sv
// ============================================================================
// Module   : rotator_arbiter
// Brief    : Two-requester arbiter sharing one 8-bit Barrel_Rotator, with a
//            one-entry valid/ready output register and saturating counters.
//            Optional macro ROTATOR_ARB_RR_EN selects round-robin tie-breaking
//            (default build: fixed priority, requester 0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module Barrel_Rotator (
    input  logic [7:0] data_in,
    input  logic       lr,
    input  logic [2:0] amount,
    output logic [7:0] data_out
);
    // A right rotate by N is a left rotate by (8 - N) mod 8.
    logic [2:0] w_left_amt;
    logic [7:0] w_stage [0:3];

    assign w_left_amt = lr ? amount : 3'(3'd0 - amount);
    assign w_stage[0] = data_in;

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_stage
            localparam int c_SHIFT = 1 << k;
            assign w_stage[k+1] = w_left_amt[k]
                ? {w_stage[k][7-c_SHIFT:0], w_stage[k][7:8-c_SHIFT]}
                : w_stage[k];
        end
    endgenerate

    assign data_out = w_stage[3];
endmodule

module rotator_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_data,
    input  logic             req0_lr,
    input  logic [2:0]       req0_amount,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_data,
    input  logic             req1_lr,
    input  logic [2:0]       req1_amount,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_id,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic             w_slot_free;
    logic             w_tie_winner;
    logic             w_grant;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_accept;
    logic [7:0]       w_rot_in;
    logic             w_rot_lr;
    logic [2:0]       w_rot_amount;
    logic [7:0]       w_rot_out;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_id;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

`ifdef ROTATOR_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_last <= w_acc1;
        end
    end

    assign w_tie_winner = ~r_last;
`else
    assign w_tie_winner = 1'b0;
`endif

    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = w_tie_winner;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_slot_free = (r_state == ST_EMPTY) || rsp_ready;
    assign req0_ready  = !rst && w_slot_free && (w_grant == 1'b0);
    assign req1_ready  = !rst && w_slot_free && (w_grant == 1'b1);
    assign w_acc0      = req0_valid && req0_ready;
    assign w_acc1      = req1_valid && req1_ready;
    assign w_accept    = w_acc0 || w_acc1;

    assign w_rot_in     = w_grant ? req1_data   : req0_data;
    assign w_rot_lr     = w_grant ? req1_lr     : req0_lr;
    assign w_rot_amount = w_grant ? req1_amount : req0_amount;

    Barrel_Rotator u_rotator (
        .data_in  (w_rot_in),
        .lr       (w_rot_lr),
        .amount   (w_rot_amount),
        .data_out (w_rot_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Accept can only happen in FULL when the consumer drains the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
            ST_FULL:  if (rsp_ready && !w_accept) w_state_next = ST_EMPTY;
            default:  w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data <= 8'h00;
            r_rsp_id   <= 1'b0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else if (w_accept) begin
            r_rsp_data <= w_rot_out;
            r_rsp_id   <= w_acc1;
            if (w_acc0 && (r_cnt0 != c_CNT_MAX)) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_acc1 && (r_cnt1 != c_CNT_MAX)) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;
endmodule

`default_nettype wire

// File: tb/tb_rotator_arbiter.sv
// Testbench for rotator_arbiter: directed steps plus random traffic against a
// behavioural model; a second instance with CNT_W = 2 exercises saturation.
module tb_rotator_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_lr, req1_lr;
    logic [2:0] req0_amount, req1_amount;
    logic       rsp_ready;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [7:0]  rsp_data;
    logic [15:0] cnt0, cnt1;

    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
    logic [7:0]  s_rsp_data;
    logic [1:0]  s_cnt0, s_cnt1;

    int checks = 0;
    int errors = 0;

`ifdef ROTATOR_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Behavioural model state
    int m_have = 0, m_data = 0, m_id = 0, m_last = 1, m_cnt0 = 0, m_cnt1 = 0;
    logic [7:0] held;

    always #5 clk = ~clk;

    rotator_arbiter #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_lr(req0_lr), .req0_amount(req0_amount),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_lr(req1_lr), .req1_amount(req1_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .cnt0(cnt0), .cnt1(cnt1)
    );

    rotator_arbiter #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_data(req0_data),
        .req0_lr(req0_lr), .req0_amount(req0_amount),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_data(req1_data),
        .req1_lr(req1_lr), .req1_amount(req1_amount),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data),
        .rsp_id(s_rsp_id), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    function automatic int rot(int d, int lr, int a);
        if (a == 0) return d;
        if (lr != 0) return ((d << a) | (d >> (8 - a))) & 255;
        return ((d >> a) | (d << (8 - a))) & 255;
    endfunction

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check readies before the edge, advance the model, check outputs after.
    task automatic cycle();
        int any, sf, win, acc;
        @(negedge clk);
        any = (req0_valid || req1_valid) ? 1 : 0;
        sf  = (m_have == 0 || rsp_ready) ? 1 : 0;
        if (req0_valid && req1_valid) win = (RR && m_last == 0) ? 1 : 0;
        else                          win = req1_valid ? 1 : 0;
        acc = (!rst && sf != 0 && any != 0) ? 1 : 0;
        if (rst || sf == 0 || any != 0) begin
            check("req0_ready", req0_ready, (acc != 0 && win == 0));
            check("req1_ready", req1_ready, (acc != 0 && win == 1));
            check("s_req0_ready", s_req0_ready, (acc != 0 && win == 0));
            check("s_req1_ready", s_req1_ready, (acc != 0 && win == 1));
        end
        @(posedge clk);
        if (rst) begin
            m_have = 0; m_data = 0; m_id = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
        end else if (acc != 0) begin
            m_data = (win == 0) ? rot(req0_data, req0_lr, req0_amount)
                                : rot(req1_data, req1_lr, req1_amount);
            m_have = 1; m_id = win; m_last = win;
            if (win == 0) m_cnt0++; else m_cnt1++;
        end else if (m_have != 0 && rsp_ready) begin
            m_have = 0;
        end
        #1;
        check("rsp_valid", rsp_valid, m_have);
        if (m_have != 0 || rst) begin
            check("rsp_data", rsp_data, m_data);
            check("rsp_id", rsp_id, m_id);
        end
        check("cnt0", cnt0, sat(m_cnt0, 65535));
        check("cnt1", cnt1, sat(m_cnt1, 65535));
        check("s_cnt0", s_cnt0, sat(m_cnt0, 3));
        check("s_cnt1", s_cnt1, sat(m_cnt1, 3));
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 8'h5A; req0_lr = 1'b1; req0_amount = 3'd2;
        req1_data = 8'h3C; req1_lr = 1'b0; req1_amount = 3'd3;

        // Reset with both valids high
        repeat (2) cycle();
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_cnt0", cnt0, 0);
        check("reset_cnt1", cnt1, 0);

        // Single left rotate
        rst = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h81; req0_lr = 1'b1; req0_amount = 3'd1;
        cycle();
        req0_valid = 1'b0;
        check("left_data", rsp_data, 8'h03);
        check("left_id", rsp_id, 0);
        check("left_cnt0", cnt0, 1);

        // Right rotate, then zero amount
        req1_valid = 1'b1; req1_data = 8'h81; req1_lr = 1'b0; req1_amount = 3'd1;
        cycle();
        check("right_data", rsp_data, 8'hC0);
        check("right_id", rsp_id, 1);
        req1_data = 8'hA5; req1_lr = 1'b1; req1_amount = 3'd0;
        cycle();
        check("zero_data", rsp_data, 8'hA5);
        check("zero_id", rsp_id, 1);
        req1_valid = 1'b0;

        // Contention from a fresh reset
        rst = 1'b1; cycle(); rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_data = 8'($urandom); req1_data = 8'($urandom);
            cycle();
            check("contend_id", rsp_id, RR ? (i % 2) : 0);
            check("contend_valid", rsp_valid, 1);
        end
        check("contend_cnt0", cnt0, RR ? 2 : 4);
        check("contend_cnt1", cnt1, RR ? 2 : 0);

        // Backpressure
        req1_valid = 1'b0; req0_data = 8'h96; req0_lr = 1'b1; req0_amount = 3'd4;
        cycle();
        rsp_ready = 1'b0; held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            req0_data = 8'($urandom);
            cycle();
            check("bp_hold", rsp_data, held);
        end
        rsp_ready = 1'b1; req0_data = 8'h0F; req0_lr = 1'b0; req0_amount = 3'd2;
        cycle();
        check("bp_release", rsp_data, 8'hC3);
        req0_valid = 1'b0;
        cycle();

        // Saturation on the CNT_W = 2 instance
        rst = 1'b1; cycle(); rst = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_data = 8'($urandom); req0_amount = 3'($urandom);
            cycle();
            check("sat_cnt0", s_cnt0, (i < 3) ? i + 1 : 3);
            check("sat_data", s_rsp_data, rot(req0_data, req0_lr, req0_amount));
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 39) == 0);
            req0_valid  = 1'($urandom);
            req1_valid  = 1'($urandom);
            req0_data   = 8'($urandom); req1_data = 8'($urandom);
            req0_lr     = 1'($urandom); req1_lr   = 1'($urandom);
            req0_amount = 3'($urandom); req1_amount = 3'($urandom);
            rsp_ready   = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
